// File: rtl/input_conditioner.sv
// Conditions asynchronous board pins into clean levels, rise/fall strobes and a long-press strobe.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from the first sampling edge to level_o/rise_o/fall_o.
// No backpressure: outputs are free-running levels and one-cycle strobes.
module input_conditioner #(
   parameter int              N_CH            = 4,
   parameter int              SYNC_STAGES     = 2,
   parameter int              DEBOUNCE_CYCLES = 20000,
   parameter int              LONG_CYCLES     = 2**22,
   parameter logic [N_CH-1:0] INVERT          = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_i,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o,
   output logic [N_CH-1:0] long_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LC_W  = $clog2(LONG_CYCLES + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(LONG_CYCLES - 1);

   logic [N_CH-1:0]  sync_q [SYNC_STAGES];
   logic [N_CH-1:0]  s;

   logic [N_CH-1:0]  level_q, level_d;
   logic [N_CH-1:0]  rise_q, rise_d;
   logic [N_CH-1:0]  fall_q, fall_d;
   logic [N_CH-1:0]  long_q, long_d;
   logic [N_CH-1:0]  done_q, done_d;
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [LC_W-1:0]  lc_q  [N_CH];
   logic [LC_W-1:0]  lc_d  [N_CH];

   // Synchroniser chain; polarity is fixed up before the first flop so everything after is active-high.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= raw_i ^ INVERT;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Debounce, edge strobes and long-press detection for every channel.
   always_comb begin
      level_d = level_q;
      done_d  = done_q;
      long_d  = '0;
      cnt_d   = cnt_q;
      lc_d    = lc_q;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (s[ch] == level_q[ch]) begin
            cnt_d[ch] = '0;
         end else if (cnt_q[ch] == DEB_LAST) begin
            level_d[ch] = s[ch];
            cnt_d[ch]   = '0;
         end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
         end

         if (!level_q[ch]) begin
            lc_d[ch]   = '0;
            done_d[ch] = 1'b0;
         end else if (!done_q[ch]) begin
            lc_d[ch] = lc_q[ch] + LC_W'(1);
            if (lc_q[ch] == LC_LAST) begin
               done_d[ch] = 1'b1;
               // A release accepted on this very edge wins: fall and long never coincide.
               long_d[ch] = level_d[ch];
            end
         end
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
   end

   // Per-channel state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         long_q  <= '0;
         done_q  <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            cnt_q[ch] <= '0;
            lc_q[ch]  <= '0;
         end
      end else begin
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         long_q  <= long_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         lc_q    <= lc_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign long_o  = long_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: reference model feeds a scoreboard queue, monitor compares every cycle.
// Latency: expectations are pushed at each posedge and checked on the following negedge.
// No backpressure: outputs are checked every cycle once reset has been seen.
module tb_input_conditioner;

   localparam int N  = 4;
   localparam int SY = 2;
   localparam int DB = 8;
   localparam int LG = 16;
   localparam logic [N-1:0] INV = 4'b1000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] raw_i = 4'b1000;
   logic [N-1:0] level_o, rise_o, fall_o, long_o;

   int checks = 0;
   int passes = 0;

   typedef struct packed {
      logic [N-1:0] lvl;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] lng;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   input_conditioner #(
      .N_CH(N), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .INVERT(INV)
   ) dut (
      .clk(clk), .reset(reset), .raw_i(raw_i),
      .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .long_o(long_o)
   );

   function void check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
   endfunction

   // Reference model: a level flips once DB consecutive pin samples, seen SY edges late,
   // all disagree with it; long fires LG edges after the rise if the level is still high.
   bit hist [N][$];
   bit m_lvl [N];
   int age [N];
   bit started = 1'b0;

   always @(posedge clk) begin
      exp_t e;
      bit   pin, flip, nl;
      e = '0;
      if (reset) begin
         started = 1'b1;
         for (int ch = 0; ch < N; ch++) begin
            hist[ch].delete();
            for (int k = 0; k < SY + DB; k++) hist[ch].push_back(1'b0);
            m_lvl[ch] = 1'b0;
            age[ch]   = 0;
         end
      end else if (started) begin
         for (int ch = 0; ch < N; ch++) begin
            pin = raw_i[ch] ^ INV[ch];
            hist[ch].push_back(pin);
            if (hist[ch].size() > SY + DB) void'(hist[ch].pop_front());
            flip = 1'b1;
            for (int k = 0; k < DB; k++)
               if (hist[ch][k] == m_lvl[ch]) flip = 1'b0;
            nl = flip ? ~m_lvl[ch] : m_lvl[ch];
            e.rise[ch] = nl & ~m_lvl[ch];
            e.fall[ch] = ~nl & m_lvl[ch];
            if (!nl)            age[ch] = 0;
            else if (!m_lvl[ch]) age[ch] = 0;
            else                age[ch] = age[ch] + 1;
            e.lng[ch] = nl && (age[ch] == LG);
            e.lvl[ch] = nl;
            m_lvl[ch] = nl;
         end
      end
      if (started) exp_q.push_back(e);
   end

   // Monitor: one scoreboard comparison per cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs", {16'h0, level_o, rise_o, fall_o, long_o}, {16'h0, e});
      end
   end

   // Counts edges until the chosen strobe is seen; an expired bound reports a wrong count.
   task automatic wait_evt(input int kind, input int ch, input int want, input string name);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         case (kind)
            0:       seen = rise_o[ch];
            1:       seen = fall_o[ch];
            default: seen = long_o[ch];
         endcase
      end
      check(name, n, want);
   endtask

   initial begin
      int cnt;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_level_inv_idle", {31'd0, level_o[3]}, 0);

      raw_i[0] = 1'b1;
      wait_evt(0, 0, SY + DB, "t1_rise");
      wait_evt(2, 0, LG, "t4_long");
      cnt = 0;
      repeat (24) begin
         @(negedge clk);
         if (long_o[0]) cnt++;
      end
      check("t4_no_repeat", cnt, 0);
      raw_i[0] = 1'b0;
      wait_evt(1, 0, SY + DB, "t4_fall");

      raw_i[1] = 1'b1;
      repeat (7) @(negedge clk);
      raw_i[1] = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (level_o[1] || rise_o[1] || fall_o[1]) cnt++;
      end
      check("t2_short_pulse", cnt, 0);

      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         raw_i[2] = ~raw_i[2];
         repeat (3) begin
            @(negedge clk);
            if (rise_o[2]) cnt++;
         end
      end
      check("t3_no_rise_bounce", cnt, 0);
      raw_i[2] = 1'b1;
      wait_evt(0, 2, SY + DB, "t3_rise");

      raw_i[3] = 1'b0;
      wait_evt(0, 3, SY + DB, "t5_rise_inv");

      raw_i[0] = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t6_reset_outs", {16'h0, level_o, rise_o, fall_o, long_o}, 0);
      end
      reset = 1'b0;
      wait_evt(0, 0, SY + DB, "t6_rise_after_reset");

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int ch = 0; ch < N; ch++)
            if ($urandom_range(0, 29) == 0) raw_i[ch] = ~raw_i[ch];
         reset = ($urandom_range(0, 799) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
